id_stage_hz: RTL and testbench

- Parametrised decode stage with an ID/EX pipeline register.
- Successor to the fixed-width decode stage; decodes opcode into a control vector and tracks a valid bit per slot.
- Adds an internal load-use hazard detector, flush-over-stall priority, a HALT drain state machine and an accepted-instruction counter.
- Sits between the IF/ID register and the EX stage; also drives the register-file read addresses.

---
 rtl/id_stage_hz.sv | 195 +++++++++++++++++++
 tb/tb_id_stage_hz.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// Decode stage with ID/EX pipeline register, load-use hazard detection,
// flush-over-stall priority, HALT drain sequencer and accepted-instruction counter.
module id_stage_hz #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int IMM8_WIDTH   = 8,
  parameter int REG_WIDTH    = 4,
  parameter int OP_WIDTH     = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_d_i,
  input  logic [DATA_WIDTH-1:0] instr_d_i,
  input  logic                  valid_d_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [REG_WIDTH-1:0]  rf_r1_o,
  output logic [REG_WIDTH-1:0]  rf_r2_o,
  output logic                  stall_fd_o,
  output logic                  jump_o,
  output logic [IMM8_WIDTH-1:0] jump_addr_o,
  output logic                  valid_e_o,
  output logic [ADDR_WIDTH-1:0] pc_e_o,
  output logic [REG_WIDTH-1:0]  rs_e_o,
  output logic [REG_WIDTH-1:0]  rt_e_o,
  output logic [REG_WIDTH-1:0]  rd_e_o,
  output logic [IMM8_WIDTH-1:0] imm_e_o,
  output logic [8:0]            ctrl_e_o,
  output logic                  illegal_o,
  output logic                  halted_o,
  output logic [CNT_WIDTH-1:0]  instr_cnt_o
);

  localparam int CTRL_W = 9;
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Control vector bit positions, MSB first: RegWrite .. Floating
  localparam logic [CTRL_W-1:0] C_REGWRITE = 9'h100;
  localparam logic [CTRL_W-1:0] C_ALUOP    = 9'h080;
  localparam logic [CTRL_W-1:0] C_BRANCH   = 9'h040;
  localparam logic [CTRL_W-1:0] C_MEMREAD  = 9'h020;
  localparam logic [CTRL_W-1:0] C_REGDST   = 9'h010;
  localparam logic [CTRL_W-1:0] C_MEMWRITE = 9'h008;
  localparam logic [CTRL_W-1:0] C_MEMTOREG = 9'h004;
  localparam logic [CTRL_W-1:0] C_MOV      = 9'h002;
  localparam logic [CTRL_W-1:0] C_FLOAT    = 9'h001;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_MOV  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_FADD = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_FMUL = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_ILLC = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_ILLD = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_ILLE = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(15);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [OP_WIDTH-1:0] op);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: c = C_REGWRITE | C_REGDST | C_ALUOP;
      OP_LW:                         c = C_REGWRITE | C_MEMREAD | C_MEMTOREG;
      OP_SW:                         c = C_MEMWRITE;
      OP_BEQ:                        c = C_BRANCH | C_ALUOP;
      OP_MOV:                        c = C_REGWRITE | C_MOV;
      OP_FADD, OP_FMUL:              c = C_REGWRITE | C_REGDST | C_FLOAT;
      default:                       c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_illegal(input logic [OP_WIDTH-1:0] op);
    return (op == OP_ILLC) || (op == OP_ILLD) || (op == OP_ILLE);
  endfunction

  logic [OP_WIDTH-1:0]   op_p0;
  logic [REG_WIDTH-1:0]  rs_p0, rt_p0, rd_p0;
  logic [IMM8_WIDTH-1:0] imm_p0;
  logic                  lu_p0, run_p0, load_p0, halt_p0;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic [REG_WIDTH-1:0]  rs_p1, rt_p1, rd_p1;
  logic [IMM8_WIDTH-1:0] imm_p1;
  logic [CTRL_W-1:0]     ctrl_p1;
  logic                  illegal_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;
  state_t                state_p1;
  logic [DCNT_W-1:0]     drain_p1;

  // ---- ID stage (p0): field slicing, hazard and acceptance decisions ----
  assign op_p0  = instr_d_i[DATA_WIDTH-1 -: OP_WIDTH];
  assign rs_p0  = instr_d_i[3*REG_WIDTH-1 -: REG_WIDTH];
  assign rt_p0  = instr_d_i[2*REG_WIDTH-1 -: REG_WIDTH];
  assign rd_p0  = instr_d_i[REG_WIDTH-1:0];
  assign imm_p0 = instr_d_i[IMM8_WIDTH-1:0];

  // A load in EX whose destination (rt) feeds either source of the ID instruction
  assign lu_p0   = valid_d_i & vld_p1 & (|(ctrl_p1 & C_MEMREAD)) &
                   ((rt_p1 == rs_p0) | (rt_p1 == rt_p0));
  assign run_p0  = (state_p1 == RUN);
  assign halt_p0 = valid_d_i & run_p0 & (op_p0 == OP_HALT) & ~flush_i & ~stall_i & ~lu_p0;
  assign load_p0 = valid_d_i & run_p0 & ~flush_i & ~stall_i & ~lu_p0 &
                   (op_p0 != OP_HALT) & (op_p0 != OP_JMP);

  assign rf_r1_o     = rs_p0;
  assign rf_r2_o     = rt_p0;
  assign stall_fd_o  = lu_p0 | stall_i | (state_p1 == HALTED);
  assign jump_o      = valid_d_i & (op_p0 == OP_JMP) & ~flush_i & ~lu_p0 & ~stall_i & run_p0;
  assign jump_addr_o = imm_p0;

  // ---- ID/EX register (p1) ----
  // ID/EX slot: flush bubbles, stall holds, otherwise load or bubble
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      rs_p1   <= '0;
      rt_p1   <= '0;
      rd_p1   <= '0;
      imm_p1  <= '0;
      ctrl_p1 <= '0;
    end else if (!stall_i) begin
      vld_p1  <= load_p0;
      pc_p1   <= load_p0 ? pc_d_i : '0;
      rs_p1   <= load_p0 ? rs_p0 : '0;
      rt_p1   <= load_p0 ? rt_p0 : '0;
      rd_p1   <= load_p0 ? rd_p0 : '0;
      imm_p1  <= load_p0 ? imm_p0 : '0;
      ctrl_p1 <= load_p0 ? decode_ctrl(op_p0) : '0;
    end
  end

  // Illegal-opcode pulse and accepted-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_p1 <= 1'b0;
      cnt_p1     <= '0;
    end else begin
      illegal_p1 <= load_p0 & is_illegal(op_p0);
      if (load_p0) cnt_p1 <= cnt_p1 + CNT_WIDTH'(1);
    end
  end

  // HALT sequencer: drain the pipe for DRAIN_CYCLES unstalled cycles, then halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= RUN;
      drain_p1 <= '0;
    end else begin
      case (state_p1)
        RUN: begin
          if (halt_p0) begin
            state_p1 <= DRAIN;
            drain_p1 <= DCNT_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (flush_i) begin
            state_p1 <= RUN;
            drain_p1 <= '0;
          end else if (!stall_i) begin
            if (drain_p1 == '0) state_p1 <= HALTED;
            else                drain_p1 <= drain_p1 - DCNT_W'(1);
          end
        end
        HALTED:  state_p1 <= HALTED;
        default: state_p1 <= RUN;
      endcase
    end
  end

  assign valid_e_o   = vld_p1;
  assign pc_e_o      = pc_p1;
  assign rs_e_o      = rs_p1;
  assign rt_e_o      = rt_p1;
  assign rd_e_o      = rd_p1;
  assign imm_e_o     = imm_p1;
  assign ctrl_e_o    = ctrl_p1;
  assign illegal_o   = illegal_p1;
  assign halted_o    = (state_p1 == HALTED);
  assign instr_cnt_o = cnt_p1;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: directed vector table, counter wrap, and a random run
// against a behavioural model.
module tb_id_stage_hz;

  localparam int DRAIN = 3;

  logic        clk;
  logic        r, v, st, fl;
  logic [7:0]  pc;
  logic [15:0] ins;

  logic [3:0]  rf_r1, rf_r2, rs_e, rt_e, rd_e;
  logic        stall_fd, jump, valid_e, illegal, halted;
  logic [7:0]  jump_addr, pc_e, imm_e;
  logic [8:0]  ctrl_e;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;

  id_stage_hz dut (
    .clk(clk), .rst(r), .pc_d_i(pc), .instr_d_i(ins), .valid_d_i(v),
    .stall_i(st), .flush_i(fl), .rf_r1_o(rf_r1), .rf_r2_o(rf_r2),
    .stall_fd_o(stall_fd), .jump_o(jump), .jump_addr_o(jump_addr),
    .valid_e_o(valid_e), .pc_e_o(pc_e), .rs_e_o(rs_e), .rt_e_o(rt_e),
    .rd_e_o(rd_e), .imm_e_o(imm_e), .ctrl_e_o(ctrl_e), .illegal_o(illegal),
    .halted_o(halted), .instr_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] ctrl_tab [16];
  logic       m_valid, m_ill;
  logic [7:0] m_pc, m_imm;
  logic [3:0] m_op, m_rs, m_rt, m_rd;
  int         m_cnt, m_mode, m_remain;  // mode: 0 run, 1 draining, 2 halted

  function automatic logic model_lu();
    return v && m_valid && (m_op == 4'd5) && (m_rt == ins[11:8] || m_rt == ins[7:4]);
  endfunction

  task automatic model_step();
    logic [3:0] op;
    logic lu, acc, hgo;
    op  = ins[15:12];
    lu  = model_lu();
    acc = !r && !fl && !st && !lu && m_mode == 0 && v && op != 4'd8 && op != 4'd15;
    hgo = !r && !fl && !st && !lu && m_mode == 0 && v && op == 4'd15;
    if (r) begin
      m_valid = 0; m_pc = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0;
      m_ill = 0; m_cnt = 0; m_mode = 0; m_remain = 0;
    end else begin
      m_ill = acc && op >= 4'd12 && op <= 4'd14;
      if (fl || !st) begin
        m_valid = acc;
        m_pc  = acc ? pc : 8'h0;
        m_op  = acc ? op : 4'h0;
        m_rs  = acc ? ins[11:8] : 4'h0;
        m_rt  = acc ? ins[7:4] : 4'h0;
        m_rd  = acc ? ins[3:0] : 4'h0;
        m_imm = acc ? ins[7:0] : 8'h0;
      end
      if (acc) m_cnt = (m_cnt + 1) % 65536;
      if (hgo) begin
        m_mode = 1; m_remain = DRAIN;
      end else if (m_mode == 1) begin
        if (fl) m_mode = 0;
        else if (!st) begin
          m_remain--;
          if (m_remain == 0) m_mode = 2;
        end
      end
    end
  endtask

  // Drive inputs, let combinational outputs settle
  task automatic apply(input logic rr, input logic [7:0] p, input logic [15:0] i,
                       input logic vv, input logic ss, input logic ff);
    r = rr; pc = p; ins = i; v = vv; st = ss; fl = ff;
    #1;
  endtask

  // Clock edge, step the model, sample after the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model_comb();
    logic lu;
    lu = model_lu();
    chk("stall_fd", 32'(stall_fd), 32'(lu || st || m_mode == 2));
    chk("jump", 32'(jump), 32'(v && ins[15:12] == 4'd8 && !fl && !lu && !st && m_mode == 0));
    chk("jump_addr", 32'(jump_addr), 32'(ins[7:0]));
    chk("rf_r1", 32'(rf_r1), 32'(ins[11:8]));
    chk("rf_r2", 32'(rf_r2), 32'(ins[7:4]));
  endtask

  task automatic chk_model_reg();
    chk("valid_e", 32'(valid_e), 32'(m_valid));
    chk("pc_e", 32'(pc_e), 32'(m_pc));
    chk("rs_e", 32'(rs_e), 32'(m_rs));
    chk("rt_e", 32'(rt_e), 32'(m_rt));
    chk("rd_e", 32'(rd_e), 32'(m_rd));
    chk("imm_e", 32'(imm_e), 32'(m_imm));
    chk("ctrl_e", 32'(ctrl_e), 32'(m_valid ? ctrl_tab[m_op] : 9'h0));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("instr_cnt", 32'(cnt), 32'(m_cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        v, st, fl;
    logic        e_sfd, e_jmp, e_vld;
    logic [8:0]  e_ctrl;
    logic        e_ill, e_hlt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tab [29];

  function automatic vec_t mk(input logic rr, input logic [15:0] i, input logic vv,
                              input logic ss, input logic ff, input logic sfd,
                              input logic jmp, input logic vld, input logic [8:0] c,
                              input logic il, input logic hl, input logic [15:0] n);
    vec_t t;
    t.rst = rr; t.instr = i; t.v = vv; t.st = ss; t.fl = ff;
    t.e_sfd = sfd; t.e_jmp = jmp; t.e_vld = vld; t.e_ctrl = c;
    t.e_ill = il; t.e_hlt = hl; t.e_cnt = n;
    return t;
  endfunction

  initial begin
    ctrl_tab[0]  = 9'h000; ctrl_tab[1]  = 9'h190; ctrl_tab[2]  = 9'h190;
    ctrl_tab[3]  = 9'h190; ctrl_tab[4]  = 9'h190; ctrl_tab[5]  = 9'h124;
    ctrl_tab[6]  = 9'h008; ctrl_tab[7]  = 9'h0C0; ctrl_tab[8]  = 9'h000;
    ctrl_tab[9]  = 9'h102; ctrl_tab[10] = 9'h111; ctrl_tab[11] = 9'h111;
    ctrl_tab[12] = 9'h000; ctrl_tab[13] = 9'h000; ctrl_tab[14] = 9'h000;
    ctrl_tab[15] = 9'h000;

    //            rst instr    v  st fl  sfd jmp vld ctrl    ill hlt cnt
    tab[0]  = mk(1, 16'h0000, 0, 0, 0,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[1]  = mk(0, 16'h1123, 1, 0, 0,  0,  0,  1, 9'h190, 0,  0,  1);
    tab[2]  = mk(0, 16'h5040, 1, 0, 0,  0,  0,  1, 9'h124, 0,  0,  2);
    tab[3]  = mk(0, 16'h1412, 1, 0, 0,  1,  0,  0, 9'h000, 0,  0,  2);
    tab[4]  = mk(0, 16'h1412, 1, 0, 0,  0,  0,  1, 9'h190, 0,  0,  3);
    tab[5]  = mk(0, 16'h6000, 1, 1, 1,  1,  0,  0, 9'h000, 0,  0,  3);
    tab[6]  = mk(0, 16'h8042, 1, 0, 0,  0,  1,  0, 9'h000, 0,  0,  3);
    tab[7]  = mk(0, 16'h8042, 1, 1, 0,  1,  0,  0, 9'h000, 0,  0,  3);
    tab[8]  = mk(0, 16'hC000, 1, 0, 0,  0,  0,  1, 9'h000, 1,  0,  4);
    tab[9]  = mk(0, 16'h0000, 1, 0, 0,  0,  0,  1, 9'h000, 0,  0,  5);
    tab[10] = mk(0, 16'hF000, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  5);
    tab[11] = mk(0, 16'h1123, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  5);
    tab[12] = mk(0, 16'h1123, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  5);
    tab[13] = mk(0, 16'h1123, 1, 0, 0,  0,  0,  0, 9'h000, 0,  1,  5);
    tab[14] = mk(0, 16'h1123, 1, 0, 0,  1,  0,  0, 9'h000, 0,  1,  5);
    tab[15] = mk(1, 16'h0000, 0, 0, 0,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[16] = mk(0, 16'hF000, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[17] = mk(0, 16'h0000, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[18] = mk(0, 16'h0000, 1, 0, 1,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[19] = mk(0, 16'h1123, 1, 0, 0,  0,  0,  1, 9'h190, 0,  0,  1);
    tab[20] = mk(0, 16'h1123, 1, 0, 0,  0,  0,  1, 9'h190, 0,  0,  2);
    tab[21] = mk(0, 16'hF000, 1, 0, 0,  0,  0,  0, 9'h000, 0,  0,  2);
    tab[22] = mk(1, 16'h0000, 0, 0, 0,  0,  0,  0, 9'h000, 0,  0,  0);
    tab[23] = mk(0, 16'h0000, 1, 0, 0,  0,  0,  1, 9'h000, 0,  0,  1);
    tab[24] = mk(0, 16'h0000, 1, 0, 0,  0,  0,  1, 9'h000, 0,  0,  2);
    tab[25] = mk(0, 16'h0000, 1, 0, 0,  0,  0,  1, 9'h000, 0,  0,  3);
    tab[26] = mk(0, 16'h0000, 1, 0, 0,  0,  0,  1, 9'h000, 0,  0,  4);
    tab[27] = mk(0, 16'h1123, 1, 1, 0,  1,  0,  1, 9'h000, 0,  0,  4);
    tab[28] = mk(1, 16'h1123, 1, 1, 0,  0,  0,  0, 9'h000, 0,  0,  0);

    for (int i = 0; i < 29; i++) begin
      apply(tab[i].rst, 8'(i), tab[i].instr, tab[i].v, tab[i].st, tab[i].fl);
      if (!tab[i].rst) begin
        chk($sformatf("t%0d stall_fd", i), 32'(stall_fd), 32'(tab[i].e_sfd));
        chk($sformatf("t%0d jump", i), 32'(jump), 32'(tab[i].e_jmp));
        if (tab[i].e_jmp) chk($sformatf("t%0d jump_addr", i), 32'(jump_addr), 32'(tab[i].instr[7:0]));
      end
      tick();
      chk($sformatf("t%0d valid_e", i), 32'(valid_e), 32'(tab[i].e_vld));
      chk($sformatf("t%0d ctrl_e", i), 32'(ctrl_e), 32'(tab[i].e_ctrl));
      chk($sformatf("t%0d illegal", i), 32'(illegal), 32'(tab[i].e_ill));
      chk($sformatf("t%0d halted", i), 32'(halted), 32'(tab[i].e_hlt));
      chk($sformatf("t%0d instr_cnt", i), 32'(cnt), 32'(tab[i].e_cnt));
      if (tab[i].rst) chk($sformatf("t%0d pc_e", i), 32'(pc_e), 32'h0);
    end

    // ADD fields after acceptance: rs/rt/rd = 1/2/3, pc captured
    apply(1'b0, 8'h5A, 16'h1123, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, 8'h5A, 16'h1123, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add rs_e", 32'(rs_e), 32'h1);
    chk("add rt_e", 32'(rt_e), 32'h2);
    chk("add rd_e", 32'(rd_e), 32'h3);
    chk("add pc_e", 32'(pc_e), 32'h5A);

    // Counter wrap: 65535 accepts reach 0xFFFF, one more wraps to 0
    apply(1'b1, 8'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, 8'h0, 16'h2123, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 65535; k++) tick();
    chk("cnt at max", 32'(cnt), 32'hFFFF);
    tick();
    chk("cnt wrap", 32'(cnt), 32'h0);
    chk("valid after wrap", 32'(valid_e), 32'h1);

    // Random run against the model
    apply(1'b1, 8'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_model_reg();
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h5;
      apply($urandom_range(0, 99) < 2, 8'($urandom),
            {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom), 4'($urandom)},
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10);
      if (!r) chk_model_comb();
      tick();
      chk_model_reg();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
